// File: rtl/hex_display_pkg.sv
// Shared mode encodings and seven-segment constants for the hex display scheduler.
// Mode BLINK is only reachable when HEX_DISPLAY_BLINK_EN is defined.
package hex_display_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_BLINK  = 2'd2
    } mode_t;

    localparam logic [7:0] SEG_ONE   = 8'hF9;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] enc(input logic b);
        return b ? SEG_ONE : SEG_ZERO;
    endfunction

endpackage

// File: rtl/hex_display_scheduler_tick.sv
// Free-running display tick prescaler: one-cycle tick every TICK_DIV clocks,
// restartable from zero via clear.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Six-digit switch display with STATIC / SCROLL / BLINK modes advanced by KEY1.
// BLINK exists only when HEX_DISPLAY_BLINK_EN is defined; otherwise SCROLL returns to STATIC.
module hex_display_scheduler
    import hex_display_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic [0:5] SW,
    output logic [0:5] LEDR,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5,
    output logic [1:0] MODE
);

    logic       key_s1, key_s2, key_prev;
    logic       press, tick;
    mode_t      mode_q, mode_nx;
    logic [0:5] rot_q;
    logic [2:0] off_q;
    logic [2:0] idx;
    logic [7:0] seg_d [6];
    logic [7:0] hex_q [6];
`ifdef HEX_DISPLAY_BLINK_EN
    logic       vis_q;
`endif

    // Every press changes mode, so the press itself restarts the tick period.
    assign press = key_prev & ~key_s2;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (CLOCK_50),
        .rst_n (KEY0),
        .clear (press),
        .tick  (tick)
    );

    always_comb begin
        case (mode_q)
            MODE_STATIC: mode_nx = MODE_SCROLL;
`ifdef HEX_DISPLAY_BLINK_EN
            MODE_SCROLL: mode_nx = MODE_BLINK;
`else
            MODE_SCROLL: mode_nx = MODE_STATIC;
`endif
            default:     mode_nx = MODE_STATIC;
        endcase
    end

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            idx      = 3'((i + 32'(off_q)) % 6);
            seg_d[i] = enc(SW[3'(i)]);
            if (mode_q == MODE_SCROLL) begin
                seg_d[i] = enc(rot_q[idx]);
            end
`ifdef HEX_DISPLAY_BLINK_EN
            else if (mode_q == MODE_BLINK && !vis_q) begin
                seg_d[i] = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
            LEDR     <= '0;
            mode_q   <= MODE_STATIC;
            rot_q    <= '0;
            off_q    <= '0;
            hex_q    <= '{default: SEG_BLANK};
`ifdef HEX_DISPLAY_BLINK_EN
            vis_q    <= 1'b1;
`endif
        end else begin
            key_s1   <= KEY1;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            LEDR     <= SW;
            hex_q    <= seg_d;
            if (press) begin
                mode_q <= mode_nx;
                if (mode_nx == MODE_SCROLL) begin
                    rot_q <= SW;
                    off_q <= '0;
                end
`ifdef HEX_DISPLAY_BLINK_EN
                if (mode_nx == MODE_BLINK) begin
                    vis_q <= 1'b1;
                end
`endif
            end else if (tick) begin
                if (mode_q == MODE_SCROLL) begin
                    off_q <= (off_q == 3'd5) ? 3'd0 : off_q + 3'd1;
                end
`ifdef HEX_DISPLAY_BLINK_EN
                if (mode_q == MODE_BLINK) begin
                    vis_q <= ~vis_q;
                end
`endif
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign MODE = mode_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench for hex_display_scheduler (TICK_DIV = 4): a cycle-level reference
// model predicts each clock edge's outputs; a separate monitor compares them.
module tb_hex_display_scheduler;

    localparam int unsigned TD = 4;
`ifdef HEX_DISPLAY_BLINK_EN
    localparam int NMODES = 3;
`else
    localparam int NMODES = 2;
`endif

    logic       clk = 1'b0;
    logic       KEY0 = 1'b0;
    logic       KEY1 = 1'b1;
    logic [0:5] SW = '0;
    logic [0:5] LEDR;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [1:0] MODE;

    hex_display_scheduler #(.TICK_DIV(TD)) dut (
        .CLOCK_50 (clk),
        .KEY0     (KEY0),
        .KEY1     (KEY1),
        .SW       (SW),
        .LEDR     (LEDR),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .MODE     (MODE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  mode;
        logic [5:0]  led;
        logic [47:0] hex;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   done = 0;

    // Reference state: mode number, tick phase, scroll offset, blink visibility,
    // scroll snapshot, and the last three KEY1 levels seen at clock edges.
    int       m_mode = 0;
    int       m_cnt = 0;
    int       m_off = 0;
    bit       m_vis = 1;
    bit [5:0] m_rot = '0;
    bit       k_1 = 1, k_2 = 1, k_3 = 1;

    function automatic logic [7:0] f_enc(input bit b);
        return b ? 8'hF9 : 8'hC0;
    endfunction

    // Predicts DUT outputs right after the next rising edge given that edge's inputs.
    function automatic void model_step(input bit k0, input bit k1, input logic [0:5] s);
        exp_t       e;
        logic [7:0] seg;
        bit         pr, tk;
        bit [5:0]   sv;
        for (int i = 0; i < 6; i++) sv[i] = s[i];
        e.led = k0 ? {sv[0], sv[1], sv[2], sv[3], sv[4], sv[5]} : 6'b0;
        e.hex = '0;
        for (int i = 0; i < 6; i++) begin
            if (!k0) seg = 8'hFF;
            else if (m_mode == 1) seg = f_enc(m_rot[(i + m_off) % 6]);
            else if (m_mode == 2 && !m_vis) seg = 8'hFF;
            else seg = f_enc(sv[i]);
            e.hex[8*i +: 8] = seg;
        end
        if (!k0) begin
            m_mode = 0; m_cnt = 0; m_off = 0; m_vis = 1; m_rot = '0;
            k_1 = 1; k_2 = 1; k_3 = 1;
        end else begin
            pr = (k_3 == 1) && (k_2 == 0);
            tk = (m_cnt == TD - 1);
            if (pr) begin
                m_mode = (m_mode + 1) % NMODES;
                m_cnt  = 0;
                if (m_mode == 1) begin m_rot = sv; m_off = 0; end
                if (m_mode == 2) m_vis = 1;
            end else begin
                m_cnt = (m_cnt + 1) % TD;
                if (tk && m_mode == 1) m_off = (m_off + 1) % 6;
                if (tk && m_mode == 2) m_vis = !m_vis;
            end
            k_3 = k_2; k_2 = k_1; k_1 = k1;
        end
        e.mode = 2'(m_mode);
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit k0, input bit k1, input logic [0:5] s);
        @(negedge clk);
        KEY0 = k0;
        KEY1 = k1;
        SW   = s;
        model_step(k0, k1, s);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    endtask

    // Monitor: every edge with a pending prediction is a DUT output to compare.
    initial begin
        exp_t e;
        int   cyc = 0;
        while (!(done && exp_q.size() == 0) && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mode", 64'(MODE), 64'(e.mode));
                check("ledr", 64'({LEDR[0], LEDR[1], LEDR[2], LEDR[3], LEDR[4], LEDR[5]}), 64'(e.led));
                check("hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(e.hex));
            end
        end
        if (exp_q.size() != 0 || !done) begin
            checks++;
            $display("FAIL timeout: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        logic [0:5] s;
        bit         key;
        int         guard;

        repeat (3) step(0, 1, 6'b101010);
        repeat (6) step(1, 1, 6'b101010);

        // Long press: must advance exactly once.
        repeat (2)  step(1, 1, 6'b100000);
        repeat (20) step(1, 0, 6'b100000);
        repeat (30) step(1, 1, 6'b100000);

        s = 6'b111111;
        repeat (2)  step(1, 0, s);
        repeat (14) step(1, 1, s);
        repeat (2)  step(1, 0, s);
        repeat (10) step(1, 1, s);

        // Press landing on the tick edge: drop KEY1 two edges before the tick.
        for (int n = 0; n < 3; n++) begin
            s = 6'b110100;
            guard = 0;
            while (m_cnt != 1 && guard < 20) begin step(1, 1, s); guard++; end
            repeat (2)  step(1, 0, s);
            repeat (10) step(1, 1, s);
        end

        // Reset in the middle of SCROLL.
        guard = 0;
        while (m_mode != 1 && guard < 8) begin
            repeat (2) step(1, 0, 6'b011001);
            repeat (4) step(1, 1, 6'b011001);
            guard++;
        end
        repeat (7) step(1, 1, 6'b011001);
        step(0, 0, 6'b011001);
        repeat (6) step(1, 1, 6'b011001);

        key = 1;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 7) == 0) key = !key;
            s = 6'($urandom);
            step(($urandom_range(0, 59) != 0), key, s);
        end
        repeat (4) step(1, 1, s);
        done = 1;
    end

endmodule

// File: doc/hex_display_scheduler.md
HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning CLOCK_50 cycles per display tick (legal range 2 and up).
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all state is updated on its rising edge.
REQ-003 SHALL have port KEY0  input  1  reset: one clock, synchronous, active-low.
REQ-004 SHALL have port KEY1  input  1  mode-advance push-button, active-low, asynchronous to CLOCK_50.
REQ-005 SHALL have port SW  input  [0:5]  switch positions, 1 = up.
REQ-006 SHALL have port LEDR  output  [0:5]  registered copy of SW.
REQ-007 SHALL have ports HEX0..HEX5  output  8 each  active-low segments {dp,g,f,e,d,c,b,a}; HEXi is driven from SW[i].
REQ-008 SHALL have port MODE  output  2  current mode: 0 STATIC, 1 SCROLL, 2 BLINK.

Function
REQ-009 SHALL encode a bit as 8'hF9 ("1") when set and 8'hC0 ("0") when clear; blank is 8'hFF.
REQ-010 SHALL register LEDR <= SW every cycle (1-cycle latency).
REQ-011 SHALL synchronize KEY1 through 2 flops, then detect a falling edge; one press = one single-cycle event regardless of hold time.
REQ-012 SHALL apply the mode change 3 cycles after the KEY1 falling edge reaches the pin.
REQ-013 SHALL run a tick counter 0..TICK_DIV-1, pulse tick for one cycle at TICK_DIV-1, wrap to 0.
REQ-014 SHALL transition on press: STATIC->SCROLL->BLINK->STATIC.
REQ-015 SHALL, in STATIC, drive HEXi = enc(SW[i]) registered, 1-cycle latency; ticks are ignored.
REQ-016 SHALL, on entering SCROLL, load rot[0:5] <= SW and offset <= 0.
REQ-017 SHALL, in SCROLL, drive HEXi = enc(rot[(i+offset) mod 6]) and increment offset on each tick; 5 wraps to 0.
REQ-018 SHALL, in SCROLL, hold rot constant, so SW changes are not shown until SCROLL is re-entered.
REQ-019 SHALL, on entering BLINK, set vis <= 1 and toggle vis on each tick.
REQ-020 SHALL, in BLINK, drive HEXi = enc(SW[i]) when vis = 1 and 8'hFF when vis = 0.
REQ-021 SHALL clear the tick counter on every mode change so the first tick in a new mode arrives TICK_DIV cycles after entry.
REQ-022 SHALL, when press and tick coincide, take the press, discard the tick and clear the counter.

Reset
REQ-023 SHALL, while KEY0 = 0 at a clock edge, set MODE = 0, LEDR = 0, HEX0..HEX5 = 8'hFF, counter = 0, offset = 0, vis = 1, rot = 0, synchronizer flops = 1.
REQ-024 SHALL give reset precedence over press and tick in the same cycle; reset mid-SCROLL or mid-BLINK returns to STATIC.
REQ-025 SHALL show STATIC encodings on the first cycle after KEY0 = 1, with no press generated by reset release.

Configuration
REQ-026 SHALL implement the BLINK mode only when macro HEX_DISPLAY_BLINK_EN is defined.
REQ-027 SHALL, when HEX_DISPLAY_BLINK_EN is undefined, transition SCROLL->STATIC on press, never output MODE = 2, and remove the vis register.

Structure
REQ-028 SHALL place the mode encodings (STATIC/SCROLL/BLINK) and the constants SEG_ONE = 8'hF9, SEG_ZERO = 8'hC0, SEG_BLANK = 8'hFF in package hex_display_pkg.
REQ-029 SHALL implement the tick counter as sub-module tick_prescaler (parameter TICK_DIV; inputs clk, rst_n, clear; output tick).

Verification (TICK_DIV = 4)
REQ-030 SHALL cover reset: KEY0 = 0 with SW = 6'b101010 -> HEX all 8'hFF, LEDR = 0, MODE = 0; after release, next cycle HEX0 = F9, HEX1 = C0, LEDR = 101010.
REQ-031 SHALL cover press: KEY1 low for 20 cycles -> MODE goes 0->1 exactly 3 cycles after the edge and advances only once.
REQ-032 SHALL cover SCROLL: SW = 100000, enter SCROLL -> HEX0 = F9, others C0; after 4 cycles HEX5 = F9; after 24 cycles HEX0 = F9 again.
REQ-033 SHALL cover BLINK (macro defined): SW = 111111, enter BLINK -> HEX = F9 for 4 cycles, FF for 4, then F9.
REQ-034 SHALL cover press/tick collision: press lands on the tick cycle -> mode advances, offset unchanged, next tick 4 cycles later.
REQ-035 SHALL cover the macro undefined: 2 presses from STATIC -> MODE sequence 0,1,0; MODE never equals 2.
